// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port types for the cache/memory arbiter.
// Physical line address, cache line payload and read-owner tag.
package common;

   localparam int PADDR_W = 32;
   localparam int LINE_W  = 128;

   typedef logic [PADDR_W-1:0] pptr_t;
   typedef logic [LINE_W-1:0]  cacheline_t;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } memreq_owner_t;

   // Round-robin helper: the requester that should win the next tie.
   function automatic memreq_owner_t other_owner(input memreq_owner_t o);
      return (o == OWNER_IC) ? OWNER_DC : OWNER_IC;
   endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// One pending-read slot: holds a single line-read request until the arbiter grants it.
// A request that arrives while the slot is occupied is dropped and flagged.
module mem_arbiter_slot
   import common::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  pptr_t load_addr,
   input  logic  clear,
   output logic  valid,
   output pptr_t addr,
   output logic  overflow
);

   // A grant in the same cycle frees the slot, so that request is accepted.
   assign overflow = load && valid && !clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         addr  <= '0;
      end else if (load && (!valid || clear)) begin
         valid <= 1'b1;
         addr  <= load_addr;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache-line memory port between I-cache and D-cache, one read in flight.
// Optional read watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
   import common::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 63
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ic_req_ren,
   input  pptr_t      ic_req_raddr,
   output logic       ic_rec_en,
   output pptr_t      ic_rec_addr,
   output cacheline_t ic_rec_cacheline,
   input  logic       dc_req_ren,
   input  pptr_t      dc_req_raddr,
   input  logic       dc_req_wen,
   input  pptr_t      dc_req_waddr,
   input  cacheline_t dc_req_wcacheline,
   output logic       dc_rec_en,
   output pptr_t      dc_rec_addr,
   output cacheline_t dc_rec_cacheline,
   output logic       mem_req_ren,
   output pptr_t      mem_req_raddr,
   output logic       mem_req_wen,
   output pptr_t      mem_req_waddr,
   output cacheline_t mem_req_wcacheline,
   input  logic       mem_rec_en,
   input  pptr_t      mem_rec_addr,
   input  cacheline_t mem_rec_cacheline,
   output logic       overflow,
   output logic       timeout
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_READ = 1'b1
   } memarb_state_t;

   memarb_state_t state;
   memreq_owner_t owner;
   memreq_owner_t last_grant;
   pptr_t         pend_addr;

   logic  ic_valid, dc_valid;
   pptr_t ic_addr, dc_addr;
   logic  ic_ovf, dc_ovf;
   logic  ic_ok, dc_ok;
   logic  grant_ic, grant_dc;
   pptr_t grant_addr;
   logic  rsp_match;

   mem_arbiter_slot u_ic_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (ic_req_ren),
      .load_addr (ic_req_raddr),
      .clear     (grant_ic),
      .valid     (ic_valid),
      .addr      (ic_addr),
      .overflow  (ic_ovf)
   );

   mem_arbiter_slot u_dc_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (dc_req_ren),
      .load_addr (dc_req_raddr),
      .clear     (grant_dc),
      .valid     (dc_valid),
      .addr      (dc_addr),
      .overflow  (dc_ovf)
   );

   // A read to the line currently being written back waits a cycle so memory sees the write first.
   always_comb begin
      ic_ok    = ic_valid && !(dc_req_wen && (ic_addr == dc_req_waddr));
      dc_ok    = dc_valid && !(dc_req_wen && (dc_addr == dc_req_waddr));
      grant_ic = 1'b0;
      grant_dc = 1'b0;
      if (state == IDLE) begin
         if (ic_ok && dc_ok) begin
            grant_ic = (other_owner(last_grant) == OWNER_IC);
            grant_dc = !grant_ic;
         end else begin
            grant_ic = ic_ok;
            grant_dc = dc_ok;
         end
      end
   end

   assign grant_addr = grant_ic ? ic_addr : dc_addr;
   assign rsp_match  = mem_rec_en && (mem_rec_addr == pend_addr);

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             expire;
   logic             timeout_q;

   assign expire = (state == WAIT_READ) && !rsp_match && (wait_cnt == CNT_LAST);

   // Watchdog restarts on every (re)issue so re-pulses come at a fixed period.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if ((state != WAIT_READ) || rsp_match || expire) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         owner            <= OWNER_IC;
         last_grant       <= OWNER_DC;
         pend_addr        <= '0;
         mem_req_ren      <= 1'b0;
         mem_req_raddr    <= '0;
         ic_rec_en        <= 1'b0;
         ic_rec_addr      <= '0;
         ic_rec_cacheline <= '0;
         dc_rec_en        <= 1'b0;
         dc_rec_addr      <= '0;
         dc_rec_cacheline <= '0;
         overflow         <= 1'b0;
      end else begin
         mem_req_ren <= 1'b0;
         ic_rec_en   <= 1'b0;
         dc_rec_en   <= 1'b0;
         if (ic_ovf || dc_ovf) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (grant_ic || grant_dc) begin
                  mem_req_ren   <= 1'b1;
                  mem_req_raddr <= grant_addr;
                  pend_addr     <= grant_addr;
                  owner         <= grant_ic ? OWNER_IC : OWNER_DC;
                  last_grant    <= grant_ic ? OWNER_IC : OWNER_DC;
                  state         <= WAIT_READ;
               end
            end
            WAIT_READ: begin
               if (rsp_match) begin
                  if (owner == OWNER_IC) begin
                     ic_rec_en        <= 1'b1;
                     ic_rec_addr      <= mem_rec_addr;
                     ic_rec_cacheline <= mem_rec_cacheline;
                  end else begin
                     dc_rec_en        <= 1'b1;
                     dc_rec_addr      <= mem_rec_addr;
                     dc_rec_cacheline <= mem_rec_cacheline;
                  end
                  state <= IDLE;
               end
`ifdef MEM_ARBITER_TIMEOUT_EN
               else if (expire) begin
                  mem_req_ren   <= 1'b1;
                  mem_req_raddr <= pend_addr;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Evictions are written through on the next cycle regardless of read traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_wen        <= 1'b0;
         mem_req_waddr      <= '0;
         mem_req_wcacheline <= '0;
      end else begin
         mem_req_wen <= dc_req_wen;
         if (dc_req_wen) begin
            mem_req_waddr      <= dc_req_waddr;
            mem_req_wcacheline <= dc_req_wcacheline;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of requesters and memory.
module tb_mem_arbiter;
   import common::*;

   localparam int unsigned TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ic_req_ren;
   pptr_t      ic_req_raddr;
   logic       ic_rec_en;
   pptr_t      ic_rec_addr;
   cacheline_t ic_rec_cacheline;
   logic       dc_req_ren;
   pptr_t      dc_req_raddr;
   logic       dc_req_wen;
   pptr_t      dc_req_waddr;
   cacheline_t dc_req_wcacheline;
   logic       dc_rec_en;
   pptr_t      dc_rec_addr;
   cacheline_t dc_rec_cacheline;
   logic       mem_req_ren;
   pptr_t      mem_req_raddr;
   logic       mem_req_wen;
   pptr_t      mem_req_waddr;
   cacheline_t mem_req_wcacheline;
   logic       mem_rec_en;
   pptr_t      mem_rec_addr;
   cacheline_t mem_rec_cacheline;
   logic       overflow;
   logic       timeout;

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                (clk),
      .rst                (rst),
      .ic_req_ren         (ic_req_ren),
      .ic_req_raddr       (ic_req_raddr),
      .ic_rec_en          (ic_rec_en),
      .ic_rec_addr        (ic_rec_addr),
      .ic_rec_cacheline   (ic_rec_cacheline),
      .dc_req_ren         (dc_req_ren),
      .dc_req_raddr       (dc_req_raddr),
      .dc_req_wen         (dc_req_wen),
      .dc_req_waddr       (dc_req_waddr),
      .dc_req_wcacheline  (dc_req_wcacheline),
      .dc_rec_en          (dc_rec_en),
      .dc_rec_addr        (dc_rec_addr),
      .dc_rec_cacheline   (dc_rec_cacheline),
      .mem_req_ren        (mem_req_ren),
      .mem_req_raddr      (mem_req_raddr),
      .mem_req_wen        (mem_req_wen),
      .mem_req_waddr      (mem_req_waddr),
      .mem_req_wcacheline (mem_req_wcacheline),
      .mem_rec_en         (mem_rec_en),
      .mem_rec_addr       (mem_rec_addr),
      .mem_rec_cacheline  (mem_rec_cacheline),
      .overflow           (overflow),
      .timeout            (timeout)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the line address.
   function automatic cacheline_t line_of(input pptr_t a);
      return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'd17};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ic_req_ren        = 1'b0;
      ic_req_raddr      = '0;
      dc_req_ren        = 1'b0;
      dc_req_raddr      = '0;
      dc_req_wen        = 1'b0;
      dc_req_waddr      = '0;
      dc_req_wcacheline = '0;
      mem_rec_en        = 1'b0;
      mem_rec_addr      = '0;
      mem_rec_cacheline = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic respond(input pptr_t a);
      mem_rec_en        = 1'b1;
      mem_rec_addr      = a;
      mem_rec_cacheline = line_of(a);
      tick();
      mem_rec_en        = 1'b0;
      mem_rec_addr      = '0;
      mem_rec_cacheline = '0;
   endtask

   task automatic test_reset;
      do_reset();
      vectors++;
      if ({ic_rec_en, dc_rec_en, mem_req_ren, mem_req_wen, overflow, timeout} !== 6'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {ic_rec_en, dc_rec_en, mem_req_ren, mem_req_wen, overflow, timeout});
      end
      vectors++;
      if ({mem_req_raddr, mem_req_waddr, ic_rec_addr, dc_rec_addr} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_addrs: got %h %h %h %h expected all 0",
                  mem_req_raddr, mem_req_waddr, ic_rec_addr, dc_rec_addr);
      end
      vectors++;
      if ({mem_req_wcacheline, ic_rec_cacheline, dc_rec_cacheline} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_lines: nonzero cacheline output expected 0");
      end
      tick();
      tick();
      vectors++;
      if (mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_ren: got %b expected 0", mem_req_ren);
      end
   endtask

   task automatic test_ic_alone;
      bit saw_dc;
      do_reset();
      saw_dc = 1'b0;
      ic_req_ren   = 1'b1;
      ic_req_raddr = 32'h1000;
      tick();
      idle_inputs();
      saw_dc |= dc_rec_en;
      vectors++;
      if (mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_early: got ren %b expected 0 at t+1", mem_req_ren);
      end
      tick();
      saw_dc |= dc_rec_en;
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h1000) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_issue: got ren %b addr %h expected 1 00001000", mem_req_ren, mem_req_raddr);
      end
      tick();
      saw_dc |= dc_rec_en;
      vectors++;
      if (mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_ren_pulse: got %b expected 0", mem_req_ren);
      end
      tick();
      saw_dc |= dc_rec_en;
      respond(32'h1000);
      saw_dc |= dc_rec_en;
      vectors++;
      if (ic_rec_en !== 1'b1 || ic_rec_addr !== 32'h1000 || ic_rec_cacheline !== line_of(32'h1000)) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_fill: got en %b addr %h data %h expected 1 00001000 %h",
                  ic_rec_en, ic_rec_addr, ic_rec_cacheline, line_of(32'h1000));
      end
      tick();
      saw_dc |= dc_rec_en;
      vectors++;
      if (ic_rec_en !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_fill_pulse: got %b expected 0", ic_rec_en);
      end
      vectors++;
      if (saw_dc !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ic_alone_dc_quiet: got dc_rec_en seen %b expected 0", saw_dc);
      end
   endtask

   task automatic test_contention;
      do_reset();
      ic_req_ren   = 1'b1;
      ic_req_raddr = 32'h2000;
      dc_req_ren   = 1'b1;
      dc_req_raddr = 32'h3000;
      tick();
      idle_inputs();
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h2000) begin
         miscompares++;
         $display("[TB] FAIL contention_first: got ren %b addr %h expected 1 00002000", mem_req_ren, mem_req_raddr);
      end
      respond(32'h2000);
      vectors++;
      if (ic_rec_en !== 1'b1 || dc_rec_en !== 1'b0 || mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL contention_ic_fill: got ic %b dc %b ren %b expected 1 0 0", ic_rec_en, dc_rec_en, mem_req_ren);
      end
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h3000) begin
         miscompares++;
         $display("[TB] FAIL contention_second: got ren %b addr %h expected 1 00003000 at r+2", mem_req_ren, mem_req_raddr);
      end
      respond(32'h3000);
      vectors++;
      if (dc_rec_en !== 1'b1 || dc_rec_addr !== 32'h3000 || dc_rec_cacheline !== line_of(32'h3000)) begin
         miscompares++;
         $display("[TB] FAIL contention_dc_fill: got en %b addr %h expected 1 00003000", dc_rec_en, dc_rec_addr);
      end
   endtask

   task automatic test_round_robin;
      bit    rr_ic [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      bit    rr_dc [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      bit    last_dc;
      bit    pi, pd, pick_ic, got;
      pptr_t ia, da, exp_a;
      do_reset();
      last_dc = 1'b1;
      for (int r = 0; r < 5; r++) begin
         pi = rr_ic[r];
         pd = rr_dc[r];
         ia = 32'h0001_0000 + pptr_t'(r) * 32'h40;
         da = 32'h0002_0000 + pptr_t'(r) * 32'h40;
         ic_req_ren   = pi;
         ic_req_raddr = ia;
         dc_req_ren   = pd;
         dc_req_raddr = da;
         tick();
         idle_inputs();
         while (pi || pd) begin
            pick_ic = (pi && pd) ? last_dc : pi;
            exp_a   = pick_ic ? ia : da;
            got     = 1'b0;
            for (int k = 0; k < 10; k++) begin
               if (mem_req_ren === 1'b1) begin
                  got = 1'b1;
                  break;
               end
               tick();
            end
            vectors++;
            if (!got || mem_req_raddr !== exp_a) begin
               miscompares++;
               $display("[TB] FAIL rr_grant round %0d: got issued %b addr %h expected 1 %h", r, got, mem_req_raddr, exp_a);
            end
            respond(exp_a);
            vectors++;
            if ({ic_rec_en, dc_rec_en} !== (pick_ic ? 2'b10 : 2'b01)) begin
               miscompares++;
               $display("[TB] FAIL rr_route round %0d: got ic/dc %b%b expected %s", r, ic_rec_en, dc_rec_en, pick_ic ? "10" : "01");
            end
            last_dc = !pick_ic;
            if (pick_ic) pi = 1'b0;
            else         pd = 1'b0;
         end
      end
   endtask

   task automatic test_write_ordering;
      cacheline_t wl;
      do_reset();
      wl = {32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004};
      dc_req_ren   = 1'b1;
      dc_req_raddr = 32'h4000;
      tick();
      idle_inputs();
      dc_req_wen        = 1'b1;
      dc_req_waddr      = 32'h4000;
      dc_req_wcacheline = wl;
      tick();
      idle_inputs();
      vectors++;
      if (mem_req_wen !== 1'b1 || mem_req_waddr !== 32'h4000 || mem_req_wcacheline !== wl) begin
         miscompares++;
         $display("[TB] FAIL wr_issue: got wen %b addr %h expected 1 00004000", mem_req_wen, mem_req_waddr);
      end
      vectors++;
      if (mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_before_rd: got ren %b in write cycle expected 0 (read deferred)", mem_req_ren);
      end
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h4000 || mem_req_wen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_deferred_rd: got ren %b addr %h wen %b expected 1 00004000 0", mem_req_ren, mem_req_raddr, mem_req_wen);
      end
      respond(32'h4000);
      tick();
      // Different addresses: read and write issue land in the same cycle.
      dc_req_ren   = 1'b1;
      dc_req_raddr = 32'h4100;
      tick();
      idle_inputs();
      dc_req_wen        = 1'b1;
      dc_req_waddr      = 32'h4200;
      dc_req_wcacheline = ~wl;
      tick();
      idle_inputs();
      vectors++;
      if (mem_req_wen !== 1'b1 || mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h4100 || mem_req_waddr !== 32'h4200) begin
         miscompares++;
         $display("[TB] FAIL wr_rd_coincide: got wen %b ren %b raddr %h waddr %h expected 1 1 00004100 00004200",
                  mem_req_wen, mem_req_ren, mem_req_raddr, mem_req_waddr);
      end
      respond(32'h4100);
   endtask

   task automatic test_overflow;
      int n_ren;
      do_reset();
      ic_req_ren   = 1'b1;
      ic_req_raddr = 32'h6000;
      tick();
      ic_req_raddr = 32'h6040;
      tick();
      idle_inputs();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h6000 || overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ovf_free_slot: got ren %b addr %h ovf %b expected 1 00006000 0", mem_req_ren, mem_req_raddr, overflow);
      end
      respond(32'h6000);
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h6040) begin
         miscompares++;
         $display("[TB] FAIL ovf_free_second: got ren %b addr %h expected 1 00006040", mem_req_ren, mem_req_raddr);
      end
      respond(32'h6040);

      do_reset();
      dc_req_ren   = 1'b1;
      dc_req_raddr = 32'h7000;
      tick();
      idle_inputs();
      tick();
      ic_req_ren   = 1'b1;
      ic_req_raddr = 32'h7100;
      tick();
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ovf_first_load: got %b expected 0", overflow);
      end
      ic_req_raddr = 32'h7200;
      tick();
      idle_inputs();
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_set: got %b expected 1", overflow);
      end
      respond(32'h7000);
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h7100) begin
         miscompares++;
         $display("[TB] FAIL ovf_kept_req: got ren %b addr %h expected 1 00007100", mem_req_ren, mem_req_raddr);
      end
      respond(32'h7100);
      n_ren = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (mem_req_ren === 1'b1) n_ren++;
      end
      vectors++;
      if (n_ren != 0 || overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_dropped: got extra reads %0d ovf %b expected 0 1", n_ren, overflow);
      end
   endtask

   task automatic test_timeout;
      bit exp_ren, exp_to;
      do_reset();
      ic_req_ren   = 1'b1;
      ic_req_raddr = 32'h5000;
      tick();
      idle_inputs();
      tick();
      vectors++;
      if (mem_req_ren !== 1'b1 || mem_req_raddr !== 32'h5000) begin
         miscompares++;
         $display("[TB] FAIL to_issue: got ren %b addr %h expected 1 00005000", mem_req_ren, mem_req_raddr);
      end
      for (int i = 1; i <= 40; i++) begin
         tick();
`ifdef MEM_ARBITER_TIMEOUT_EN
         exp_ren = (i % TO == 0);
         exp_to  = (i >= int'(TO));
`else
         exp_ren = 1'b0;
         exp_to  = 1'b0;
`endif
         vectors++;
         if (mem_req_ren !== exp_ren || timeout !== exp_to || (exp_ren && mem_req_raddr !== 32'h5000)) begin
            miscompares++;
            $display("[TB] FAIL to_wait cycle %0d: got ren %b to %b addr %h expected %b %b 00005000",
                     i, mem_req_ren, timeout, mem_req_raddr, exp_ren, exp_to);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({mem_req_ren, ic_rec_en, dc_rec_en, mem_req_wen, timeout, overflow} !== 6'b0 || mem_req_raddr !== '0) begin
         miscompares++;
         $display("[TB] FAIL to_reset: got flags %b raddr %h expected 000000 0",
                  {mem_req_ren, ic_rec_en, dc_rec_en, mem_req_wen, timeout, overflow}, mem_req_raddr);
      end
      respond(32'h5000);
      tick();
      vectors++;
      if (ic_rec_en !== 1'b0 || mem_req_ren !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL to_stale_rsp: got ic_rec_en %b ren %b expected 0 0", ic_rec_en, mem_req_ren);
      end
   endtask

   task automatic test_random;
      bit         ic_out, dc_out, ic_iss, dc_iss;
      pptr_t      ic_exp, dc_exp;
      bit         busy;
      pptr_t      cur;
      int         cd;
      bit         pw;
      pptr_t      pwa;
      cacheline_t pwd;
      do_reset();
      ic_out = 0; dc_out = 0; ic_iss = 0; dc_iss = 0;
      ic_exp = '0; dc_exp = '0;
      busy = 0; cur = '0; cd = 0;
      pw = 0; pwa = '0; pwd = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         vectors++;
         if (mem_req_wen !== pw || (pw && (mem_req_waddr !== pwa || mem_req_wcacheline !== pwd))) begin
            miscompares++;
            $display("[TB] FAIL rnd_write cycle %0d: got wen %b addr %h expected %b %h", cyc, mem_req_wen, mem_req_waddr, pw, pwa);
         end
         if (ic_rec_en === 1'b1) begin
            vectors++;
            if (!ic_out || !ic_iss || ic_rec_addr !== ic_exp || ic_rec_cacheline !== line_of(ic_exp)) begin
               miscompares++;
               $display("[TB] FAIL rnd_ic_fill cycle %0d: got addr %h expected %h (outstanding %b)", cyc, ic_rec_addr, ic_exp, ic_out);
            end
            ic_out = 0;
         end
         if (dc_rec_en === 1'b1) begin
            vectors++;
            if (!dc_out || !dc_iss || dc_rec_addr !== dc_exp || dc_rec_cacheline !== line_of(dc_exp)) begin
               miscompares++;
               $display("[TB] FAIL rnd_dc_fill cycle %0d: got addr %h expected %h (outstanding %b)", cyc, dc_rec_addr, dc_exp, dc_out);
            end
            dc_out = 0;
         end
         if (mem_req_ren === 1'b1) begin
            vectors++;
            if (busy) begin
               miscompares++;
               $display("[TB] FAIL rnd_one_read cycle %0d: got issue %h expected none while %h in flight", cyc, mem_req_raddr, cur);
            end else if (ic_out && !ic_iss && mem_req_raddr === ic_exp) begin
               ic_iss = 1;
            end else if (dc_out && !dc_iss && mem_req_raddr === dc_exp) begin
               dc_iss = 1;
            end else begin
               miscompares++;
               $display("[TB] FAIL rnd_issue cycle %0d: got %h expected a waiting request (ic %h dc %h)", cyc, mem_req_raddr, ic_exp, dc_exp);
            end
            busy = 1;
            cur  = mem_req_raddr;
            cd   = int'($urandom_range(0, 4));
         end
         idle_inputs();
         if (busy) begin
            if (cd == 0) begin
               mem_rec_en        = 1'b1;
               mem_rec_addr      = cur;
               mem_rec_cacheline = line_of(cur);
               busy = 0;
            end else begin
               cd--;
               if ($urandom_range(0, 5) == 0) begin
                  mem_rec_en        = 1'b1;
                  mem_rec_addr      = {4'hD, 22'($urandom), 6'h0};
                  mem_rec_cacheline = '1;
               end
            end
         end
         pw = 0;
         if (cyc < 560) begin
            if (!ic_out && $urandom_range(0, 3) == 0) begin
               ic_out = 1; ic_iss = 0;
               ic_exp = {4'h1, 22'($urandom), 6'h0};
               ic_req_ren   = 1'b1;
               ic_req_raddr = ic_exp;
            end
            if (!dc_out && $urandom_range(0, 3) == 0) begin
               dc_out = 1; dc_iss = 0;
               dc_exp = {4'h3, 22'($urandom), 6'h0};
               dc_req_ren   = 1'b1;
               dc_req_raddr = dc_exp;
            end
            if ($urandom_range(0, 2) == 0) begin
               pw  = 1;
               pwa = (dc_out && $urandom_range(0, 1) == 1) ? dc_exp : {4'h3, 22'($urandom), 6'h0};
               pwd = {$urandom, $urandom, $urandom, $urandom};
               dc_req_wen        = 1'b1;
               dc_req_waddr      = pwa;
               dc_req_wcacheline = pwd;
            end
         end
         tick();
      end
      idle_inputs();
      vectors++;
      if (ic_out || dc_out) begin
         miscompares++;
         $display("[TB] FAIL rnd_drain: got outstanding ic %b dc %b expected 0 0", ic_out, dc_out);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_ic_alone();
      test_contention();
      test_round_robin();
      test_write_ordering();
      test_overflow();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      miscompares++;
      $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single cache-line memory port between the I-cache and the D-cache. Sits between both caches' `mem_req_*`/`mem_rec_*` interfaces and the memory model, with one outstanding line read at a time. D-cache evictions are written through immediately, and each fill response is routed back to the cache that owns it. Read grants alternate round-robin when both caches are waiting.

## Interface
- `TIMEOUT_CYCLES`, default 63: watchdog limit in `WAIT_READ`; used only when `MEM_ARBITER_TIMEOUT_EN` is defined.

- `clk  in  1  system clock`
- `rst  in  1  reset, synchronous, active-high`
- `ic_req_ren  in  1  I-cache line-read request pulse`
- `ic_req_raddr  in  pptr_t  I-cache read address`
- `ic_rec_en  out  1  fill valid to I-cache`
- `ic_rec_addr  out  pptr_t  fill address to I-cache`
- `ic_rec_cacheline  out  cacheline_t  fill data to I-cache`
- `dc_req_ren  in  1  D-cache line-read request pulse`
- `dc_req_raddr  in  pptr_t  D-cache read address`
- `dc_req_wen  in  1  D-cache eviction write pulse`
- `dc_req_waddr  in  pptr_t  eviction address`
- `dc_req_wcacheline  in  cacheline_t  eviction data`
- `dc_rec_en  out  1  fill valid to D-cache`
- `dc_rec_addr  out  pptr_t  fill address to D-cache`
- `dc_rec_cacheline  out  cacheline_t  fill data to D-cache`
- `mem_req_ren  out  1  read issue to memory`
- `mem_req_raddr  out  pptr_t  read address to memory`
- `mem_req_wen  out  1  write issue to memory`
- `mem_req_waddr  out  pptr_t  write address to memory`
- `mem_req_wcacheline  out  cacheline_t  write data to memory`
- `mem_rec_en  in  1  memory response valid`
- `mem_rec_addr  in  pptr_t  memory response address`
- `mem_rec_cacheline  in  cacheline_t  memory response data`
- `overflow  out  1  sticky: a read request arrived while that requester's slot was full`
- `timeout  out  1  sticky watchdog flag (tied 0 without macro)`

## Operation
- Each requester has one pending-read slot holding a valid bit and an address. A `*_req_ren` pulse loads the slot.
  - A pulse while the slot is already valid is dropped and sets `overflow`.
  - The same-cycle case where the slot is freed by a grant is not an overflow; the new request loads.
- FSM states `IDLE` and `WAIT_READ`.
  - `IDLE`: if any slot is valid, grant one, register `mem_req_ren=1` with its address, record the owner and address, clear that slot, and go to `WAIT_READ`.
  - Grant rule: only one slot valid, grant it. Both valid, grant the requester not granted last.
  - `WAIT_READ`: when `mem_rec_en=1` and `mem_rec_addr` equals the recorded address, register the response to the owner's `*_rec_*` outputs and go to `IDLE`.
  - A response with a mismatching address is ignored.
- The last-grant bit resets to D-cache, so the I-cache wins the first contended grant.
- Writes bypass the FSM: `dc_req_wen` is registered onto `mem_req_wen/waddr/wcacheline` in the next cycle, independent of state.
- Write-before-read ordering: in the cycle a write is being registered, an `IDLE` grant whose address equals `dc_req_waddr` is deferred one cycle.
- `*_rec_en`, `mem_req_ren` and `mem_req_wen` are single-cycle pulses.
- Reset values: all enables 0; addresses and cachelines 0; slots empty; state `IDLE`; `overflow` 0; `timeout` 0. Reset asserted mid-`WAIT_READ` abandons the read, and a later response to it is ignored.

## Timing
- Request pulse at cycle t: the slot is valid at t+1. If `IDLE` and uncontended, `mem_req_ren` is high at t+2.
- `mem_rec_en` matching at cycle r: `*_rec_en` high at r+1 and state `IDLE` at r+1. The next `mem_req_ren` is high at r+2 at the earliest.
- `dc_req_wen` at cycle t: `mem_req_wen` high at t+1. At most one write per cycle, with no backpressure.
- Read and write issue may coincide in the same cycle.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_READ` and clears on entering it.
  - When it reaches `TIMEOUT_CYCLES`, `mem_req_ren` is re-pulsed with the recorded address and `timeout` is set (sticky).
  - The counter restarts and the state stays `WAIT_READ`.
- Macro undefined: no counter; the arbiter waits indefinitely; `timeout` is constant 0.

## Structure
- `common` package holds the types `pptr_t`, `cacheline_t` and a new `memreq_owner_t` (enum `OWNER_IC`, `OWNER_DC`).
- The FSM state enum `memarb_state_t` stays local to the module.
- One natural sub-module: `mem_arbiter_slot` (pending-read slot with load, clear, overflow detect), instantiated twice.

## Test plan
- I-cache request alone, addr 0x1000; memory responds 3 cycles after issue. Required:
  - `mem_req_ren` at t+2 with 0x1000.
  - `ic_rec_en` one cycle after `mem_rec_en`.
  - `dc_rec_en` stays 0.
- Both requesters pulse in the same cycle (IC 0x2000, DC 0x3000). Required: IC is issued first; DC is issued at r+2 after the IC response.
- Three alternating back-to-back contention rounds. Required: grants alternate IC, DC, IC, DC.
- DC writes 0x4000 while a DC read to 0x4000 is pending. Required: `mem_req_wen` is issued no later than `mem_req_ren`.
- Second IC pulse while its slot is full and the arbiter is in `WAIT_READ`. Required: `overflow`=1, and only one IC read is issued.
- With `MEM_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, memory never responds. Required: `mem_req_ren` re-pulses every 8 cycles with the same address and `timeout`=1. Reset returns the block to `IDLE` with all outputs 0.
